gem_event_collector: RTL
========================

Name: gem_event_collector

Overview:
- Consumer end of the GEM_ASSERT / GEM_DISPLAY side-effect cells.
- Each simulated cycle the kernel presents up to NLANES fired events, each with a flavor and an ID. This block captures them, serializes them lowest lane first into a FIFO, timestamps them, and delivers them to the host readout over a valid/ready stream.
- It also raises HALT on stop/finish and counts events lost to back-pressure.

Parameters:
- NLANES, 4: event lanes per cycle (1..8).
- DEPTH, 16: FIFO entries; power of two, at least 2.
- CYCW, 32: width of the cycle timestamp counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- R  input  1  reset, asynchronous, active-high.
- TICK  input  1  simulation-cycle boundary; increments the timestamp counter.
- EV_VALID  input  NLANES  per-lane event strobe.
- EV_FLAVOR  input  3*NLANES  per-lane flavor: 0 assert, 1 assume, 2 cover, 3 stop, 4 finish, 5 display; 6 and 7 are invalid.
- EV_ID  input  32*NLANES  per-lane assertion or message ID (display carries MSG_ID).
- BUSY  output  1  collector still draining a captured group; upstream holds events.
- OUT_VALID  output  1  head FIFO entry valid.
- OUT_READY  input  1  host accepts the head entry.
- OUT_FLAVOR  output  3  head entry flavor.
- OUT_ID  output  32  head entry ID.
- OUT_CYCLE  output  CYCW  head entry timestamp.
- HALT  output  1  sticky; a stop or finish event was captured.
- DROP_CNT  output  16  saturating count of lost events.

Behaviour:
- Reset (R=1, async): all of the following clear immediately:
  - pending mask, FIFO pointers and count, cycle counter, HALT, DROP_CNT;
  - outputs OUT_VALID=0, BUSY=0, OUT_FLAVOR=0, OUT_ID=0, OUT_CYCLE=0.
  - Reset mid-drain discards pending lanes and FIFO contents.
- Cycle counter: increments on every edge with TICK=1 and wraps modulo 2^CYCW.
- Capture: on an edge where BUSY=0, HALT=0 and EV_VALID != 0:
  - latch EV_VALID & (flavor valid) into the pending mask;
  - latch flavor/ID per lane;
  - latch the current counter value as the group timestamp (pre-increment value if TICK=1 on the same edge).
  - Invalid-flavor lanes are discarded and not counted.
- BUSY = (pending != 0), derived from registers only.
- Drain: on each edge with pending != 0, the lowest set lane is written to the FIFO and its pending bit clears, provided a write is allowed.
  - A write is allowed when FIFO count < DEPTH, or when a pop occurs on the same edge.
  - When the FIFO is full the drain stalls; nothing is lost and BUSY stays high.
  - Exactly one write per edge.
  - A capture edge writes nothing; draining starts on the following edge.
- Latency: a single lane-0 event presented in cycle 0 gives OUT_VALID=1 in cycle 2. Lane k of a group appears no earlier than cycle 2 + (number of lower set lanes).
- FIFO: show-ahead. OUT_* show the head entry. A pop occurs on an edge with OUT_VALID & OUT_READY. Simultaneous push and pop leaves the count unchanged. OUT_VALID = (count != 0). Pointers wrap modulo DEPTH.
- OUT_* are stable while OUT_VALID=1 and OUT_READY=0.
- Drops: an edge with BUSY=1, HALT=0 and EV_VALID != 0 adds popcount(EV_VALID & valid flavors) to DROP_CNT, saturating at 16'hFFFF.
- HALT:
  - Set on a capture edge if any captured lane has flavor 3 or 4; remains set until R.
  - While HALT=1, new EV_VALID is ignored: no capture, no drop count.
  - Lanes already pending (including the rest of the halting group) still drain, and the FIFO still delivers to the host.
- Order: the FIFO preserves group order and, within a group, ascending lane index.

Test Plan:
- Reset then a single event: lane0 flavor 5, ID 0x2A, counter 7, OUT_READY=1 → cycle 2 shows OUT_VALID=1, FLAVOR=5, ID=0x2A, CYCLE=7; it pops the next cycle and OUT_VALID returns to 0.
- Multi-lane group: EV_VALID=4'b1011 with IDs 10/11/12/13 → BUSY high for 3 cycles; host receives IDs 10, 11, 13 in that order with identical timestamps.
- Back-pressure: DEPTH=16, OUT_READY=0, 5 groups of 4 lanes presented whenever BUSY=0 → FIFO holds 16, BUSY stays 1.
  - Events presented while BUSY count into DROP_CNT; no entry is lost.
  - Releasing OUT_READY delivers all 20 accepted entries in order.
- Halt: lane1 flavor 4 (finish) plus lane2 flavor 0 → HALT=1 next cycle and both entries are delivered. Later EV_VALID pulses leave the FIFO and DROP_CNT unchanged.
- Invalid and boundary cases:
  - flavor 7 on lane 0 → nothing enqueued, DROP_CNT unchanged;
  - DROP_CNT preset near 16'hFFFE plus 4 dropped → reads 16'hFFFF;
  - counter at 2^CYCW-1 with TICK → next stamp is 0.
- Async reset mid-drain: assert R between edges while the FIFO holds 3 entries and pending=2'b11 → OUT_VALID, BUSY, HALT and DROP_CNT drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gem_event_collector_if.sv
// Event/readout bundle between the GEM side-effect kernel, the collector and
// the host readout. The collector uses the slave view; the kernel/host side
// (or a bench) uses the master view.
interface gem_event_collector_if #(
    parameter int NLANES = 4,
    parameter int CYCW   = 32
);
    logic                  TICK;
    logic [NLANES-1:0]     EV_VALID;
    logic [3*NLANES-1:0]   EV_FLAVOR;
    logic [32*NLANES-1:0]  EV_ID;
    logic                  BUSY;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [2:0]            OUT_FLAVOR;
    logic [31:0]           OUT_ID;
    logic [CYCW-1:0]       OUT_CYCLE;
    logic                  HALT;
    logic [15:0]           DROP_CNT;

    modport master (
        output TICK, EV_VALID, EV_FLAVOR, EV_ID, OUT_READY,
        input  BUSY, OUT_VALID, OUT_FLAVOR, OUT_ID, OUT_CYCLE, HALT, DROP_CNT
    );

    modport slave (
        input  TICK, EV_VALID, EV_FLAVOR, EV_ID, OUT_READY,
        output BUSY, OUT_VALID, OUT_FLAVOR, OUT_ID, OUT_CYCLE, HALT, DROP_CNT
    );
endinterface

// File: rtl/gem_event_collector.sv
// Collects up to NLANES assert/display events per simulated cycle, serializes
// them lowest lane first into a timestamped show-ahead FIFO, raises a sticky
// HALT on stop/finish and counts events lost while a group is still draining.
module gem_event_collector #(
    parameter int NLANES = 4,
    parameter int DEPTH  = 16,
    parameter int CYCW   = 32
) (
    input  logic                 CLK,
    input  logic                 R,
    gem_event_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [NLANES-1:0] pend;
    logic [2:0]        lane_flv [NLANES];
    logic [31:0]       lane_id  [NLANES];
    logic [CYCW-1:0]   grp_cyc;
    logic [CYCW-1:0]   cyc_cnt;

    logic [2:0]        mem_flv [DEPTH];
    logic [31:0]       mem_id  [DEPTH];
    logic [CYCW-1:0]   mem_cyc [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;

    logic              halt;
    logic [15:0]       drop_cnt;

    logic [NLANES-1:0] acc_mask;
    logic              halt_hit;
    logic [2:0]        lane_f;
    logic [LW-1:0]     sel;
    logic              busy;
    logic              out_valid;
    logic              pop;
    logic              push;
    logic              cap;
    logic              drop;
    logic [16:0]       drop_sum;

    function automatic logic [4:0] popcnt(input logic [NLANES-1:0] v);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < NLANES; i++) s = s + 5'(v[i]);
        return s;
    endfunction

    // Per-lane acceptance: flavors 6/7 are dropped silently; flag stop/finish.
    always_comb begin
        acc_mask = '0;
        halt_hit = 1'b0;
        lane_f   = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_f      = bus.EV_FLAVOR[3*i +: 3];
            acc_mask[i] = bus.EV_VALID[i] && (lane_f <= 3'd5);
            if (acc_mask[i] && (lane_f == 3'd3 || lane_f == 3'd4)) halt_hit = 1'b1;
        end
    end

    // Lowest pending lane goes out first.
    always_comb begin
        sel = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (pend[i]) sel = LW'(i);
        end
    end

    assign busy      = |pend;
    assign out_valid = (cnt != '0);
    assign pop       = out_valid & bus.OUT_READY;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign push      = busy & ((cnt != FULL_CNT) | pop);
    assign cap       = ~busy & ~halt & (|bus.EV_VALID);
    assign drop      = busy & ~halt & (|bus.EV_VALID);
    assign drop_sum  = {1'b0, drop_cnt} + 17'(popcnt(acc_mask));

    // Control state: timestamp, pending mask, FIFO pointers, halt and drop count.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            cyc_cnt  <= '0;
            grp_cyc  <= '0;
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            halt     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (bus.TICK) cyc_cnt <= cyc_cnt + CYCW'(1);

            if (cap) begin
                pend    <= acc_mask;
                grp_cyc <= cyc_cnt;
                if (halt_hit) halt <= 1'b1;
            end else if (push) begin
                pend[sel] <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase

            if (drop) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Group payload latched on capture; contents are don't-care until pending.
    always_ff @(posedge CLK) begin
        if (cap) begin
            for (int i = 0; i < NLANES; i++) begin
                lane_flv[i] <= bus.EV_FLAVOR[3*i +: 3];
                lane_id[i]  <= bus.EV_ID[32*i +: 32];
            end
        end
    end

    // FIFO storage; reads are gated by OUT_VALID so stale data never shows.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_flv[wr_ptr] <= lane_flv[sel];
            mem_id[wr_ptr]  <= lane_id[sel];
            mem_cyc[wr_ptr] <= grp_cyc;
        end
    end

    assign bus.BUSY       = busy;
    assign bus.OUT_VALID  = out_valid;
    assign bus.OUT_FLAVOR = out_valid ? mem_flv[rd_ptr] : 3'd0;
    assign bus.OUT_ID     = out_valid ? mem_id[rd_ptr]  : 32'd0;
    assign bus.OUT_CYCLE  = out_valid ? mem_cyc[rd_ptr] : '0;
    assign bus.HALT       = halt;
    assign bus.DROP_CNT   = drop_cnt;
endmodule
